// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and memory-wait controller for a 5-stage core.
// Detects load-use and load-then-branch dependencies, stalls the pipeline
// while the MA-stage data memory is not ready (with a timeout that abandons
// the access), and steers branch redirects resolved in ID.
// Optional feature: define HAZARD_CTRL_PERF_EN to build saturating stall and
// flush performance counters; otherwise the counter ports read as zero.
module hazard_ctrl #(
  parameter int unsigned MEM_TO_CYC = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_is_branch_i,
  input  logic             br_taken_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       ma_rd_i,
  input  logic             ex_reg_we_i,
  input  logic             ma_reg_we_i,
  input  logic             ex_is_load_i,
  input  logic             ma_is_load_i,
  input  logic             ma_mem_req_i,
  input  logic             ma_mem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_we_o,
  output logic             idex_flush_o,
  output logic             exma_we_o,
  output logic             mawb_flush_o,
  output logic             redirect_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  // Last counter value before the wait is abandoned: the counter holds the
  // number of wait cycles already spent, so this cycle is wait number cnt+1.
  localparam logic [9:0] TO_LAST = 10'(MEM_TO_CYC - 1);

  state_t     state_q;
  logic [9:0] wait_cnt_q;

  logic load_use, br_ld, load_hazard;
  logic enter_wait, timeout, hold_wait, mem_stall;

  // A destination only matters when it is a real register (x0 is never written).
  function automatic logic rd_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  // Hazard and memory-wait classification of the current cycle.
  always_comb begin
    load_use    = ex_is_load_i & ex_reg_we_i &
                  (rd_match(ex_rd_i, id_rs1_i) | rd_match(ex_rd_i, id_rs2_i));
    br_ld       = id_is_branch_i & ma_is_load_i & ma_reg_we_i &
                  (rd_match(ma_rd_i, id_rs1_i) | rd_match(ma_rd_i, id_rs2_i));
    load_hazard = load_use | br_ld;
    enter_wait  = (state_q == RUN) & ma_mem_req_i & ~ma_mem_ready_i;
    timeout     = (state_q == MEM_WAIT) & ~ma_mem_ready_i & (wait_cnt_q == TO_LAST);
    hold_wait   = (state_q == MEM_WAIT) & ~ma_mem_ready_i & ~timeout;
    mem_stall   = enter_wait | hold_wait;
  end

  // Pipeline control outputs; reset forces a flushed, frozen pipeline.
  always_comb begin
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    ifid_flush_o = 1'b0;
    idex_we_o    = 1'b1;
    idex_flush_o = 1'b0;
    exma_we_o    = 1'b1;
    mawb_flush_o = 1'b0;
    redirect_o   = 1'b0;
    mem_err_o    = 1'b0;
    if (!rst_n) begin
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      idex_we_o    = 1'b0;
      exma_we_o    = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      mawb_flush_o = 1'b1;
    end else if (mem_stall) begin
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      idex_we_o    = 1'b0;
      exma_we_o    = 1'b0;
      mawb_flush_o = 1'b1;
    end else begin
      if (load_hazard) begin
        // Bubble into EX; any branch in ID is re-evaluated once operands arrive.
        pc_we_o      = 1'b0;
        ifid_we_o    = 1'b0;
        idex_flush_o = 1'b1;
      end else if (br_taken_i) begin
        redirect_o   = 1'b1;
        ifid_flush_o = 1'b1;
      end
      if (timeout) begin
        // Abandon the stuck access: move on and drop its write-back.
        exma_we_o    = 1'b1;
        mawb_flush_o = 1'b1;
        mem_err_o    = 1'b1;
      end
    end
  end

  // Memory-wait FSM with its wait-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 10'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (enter_wait) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 10'd1;
          end
        end
        MEM_WAIT: begin
          if (ma_mem_ready_i || timeout) begin
            state_q    <= RUN;
            wait_cnt_q <= 10'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 10'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters: stalled-PC cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized cycles, checked
// against a cycle-level reference model through an expected-value queue.
module tb_hazard_ctrl;

  localparam int unsigned MEM_TO = 4;
  localparam int unsigned CW     = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       isbr, brt;
    logic [4:0] exrd, mard;
    logic       exwe, mawe, exld, mald, req, rdy;
  } stim_t;

  typedef struct packed {
    logic [8:0]    outs;
    logic [CW-1:0] scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, ma_rd;
  logic id_is_branch, br_taken, ex_reg_we, ma_reg_we, ex_is_load, ma_is_load;
  logic ma_mem_req, ma_mem_ready;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exma_we, mawb_flush, redirect, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TO_CYC(MEM_TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_is_branch_i(id_is_branch), .br_taken_i(br_taken),
    .ex_rd_i(ex_rd), .ma_rd_i(ma_rd), .ex_reg_we_i(ex_reg_we), .ma_reg_we_i(ma_reg_we),
    .ex_is_load_i(ex_is_load), .ma_is_load_i(ma_is_load),
    .ma_mem_req_i(ma_mem_req), .ma_mem_ready_i(ma_mem_ready),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush), .idex_we_o(idex_we),
    .idex_flush_o(idex_flush), .exma_we_o(exma_we), .mawb_flush_o(mawb_flush),
    .redirect_o(redirect), .mem_err_o(mem_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  exp_t exp_q[$];
  event presented;
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model state: are we in a memory wait, and how many wait cycles so far.
  bit waiting = 0;
  int waited = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL cyc=%0d %s actual=%b required=%b", cyc, name, act, req);
  endtask

  // Apply one cycle of stimulus, predict the response, advance the model.
  task automatic cycle(input stim_t s);
    bit lu, bl, stall, tmo;
    logic pw, iw, ifl, iew, ifx, ew, mf, rd, me;
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; id_is_branch = s.isbr; br_taken = s.brt;
    ex_rd = s.exrd; ma_rd = s.mard; ex_reg_we = s.exwe; ma_reg_we = s.mawe;
    ex_is_load = s.exld; ma_is_load = s.mald; ma_mem_req = s.req; ma_mem_ready = s.rdy;

    lu = s.exld && s.exwe && s.exrd != 0 && (s.exrd == s.rs1 || s.exrd == s.rs2);
    bl = s.isbr && s.mald && s.mawe && s.mard != 0 && (s.mard == s.rs1 || s.mard == s.rs2);
    stall = 0; tmo = 0;
    if (s.rst_n && !s.rdy && (waiting || s.req)) begin
      if (waited + 1 >= int'(MEM_TO)) tmo = 1;
      else stall = 1;
    end
    if (!s.rst_n) begin
      {pw, iw, ifl, iew, ifx, ew, mf, rd, me} = 9'b001010100;
    end else if (stall) begin
      {pw, iw, ifl, iew, ifx, ew, mf, rd, me} = 9'b000000100;
    end else begin
      {pw, iw, ifl, iew, ifx, ew, mf, rd, me} = 9'b110101000;
      if (lu || bl) begin pw = 0; iw = 0; ifx = 1; end
      else if (s.brt) begin rd = 1; ifl = 1; end
      if (tmo) begin ew = 1; mf = 1; me = 1; end
    end
    e.outs = {pw, iw, ifl, iew, ifx, ew, mf, rd, me};
    e.scnt = CW'(m_scnt);
    e.fcnt = CW'(m_fcnt);
    exp_q.push_back(e);
    ->presented;

    if (!s.rst_n) begin waiting = 0; waited = 0; end
    else if (stall) begin waiting = 1; waited++; end
    else begin waiting = 0; waited = 0; end
`ifdef HAZARD_CTRL_PERF_EN
    if (!s.rst_n) begin m_scnt = 0; m_fcnt = 0; end
    else begin
      if (!pw && m_scnt < (1 << CW) - 1) m_scnt++;
      if (rd && m_fcnt < (1 << CW) - 1) m_fcnt++;
    end
`endif
  endtask

  // Monitor: the control outputs are presented every cycle once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(presented);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        check("queue_underrun", 9'd0, 9'd1);
      end else begin
        e = exp_q.pop_front();
        $display("cyc %0d outs=%b stall_cnt=%0d flush_cnt=%0d", cyc,
                 {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exma_we, mawb_flush, redirect, mem_err},
                 stall_cnt, flush_cnt);
        check("ctrl_outs",
              {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exma_we, mawb_flush, redirect, mem_err},
              e.outs);
        check("stall_cnt", 9'(stall_cnt), 9'(e.scnt));
        check("flush_cnt", 9'(flush_cnt), 9'(e.fcnt));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst_n = 0;
    repeat (2) cycle(s);
    cycle(idle());

    // load-use: lw x1 in EX, add x3,x1,x2 in ID
    s = idle(); s.exld = 1; s.exwe = 1; s.exrd = 1; s.rs1 = 1; s.rs2 = 2; cycle(s);
    cycle(idle());

    // load then taken branch: lw x5 / beq x5,x6
    s = idle(); s.exld = 1; s.exwe = 1; s.exrd = 5; s.rs1 = 5; s.rs2 = 6; s.isbr = 1; s.brt = 1; cycle(s);
    s = idle(); s.mald = 1; s.mawe = 1; s.mard = 5; s.rs1 = 5; s.rs2 = 6; s.isbr = 1; s.brt = 1; cycle(s);
    s = idle(); s.rs1 = 5; s.rs2 = 6; s.isbr = 1; s.brt = 1; cycle(s);
    cycle(idle());

    // memory wait, ready late by 3 cycles
    s = idle(); s.req = 1; repeat (3) cycle(s);
    s.rdy = 1; cycle(s);
    cycle(idle());

    // timeout with ready stuck low
    s = idle(); s.req = 1; repeat (5) cycle(s);
    cycle(idle());

    // x0 never hazards
    s = idle(); s.exld = 1; s.exwe = 1; s.exrd = 0; s.rs1 = 0; s.rs2 = 0; cycle(s);

    // reset in the middle of a wait
    s = idle(); s.req = 1; repeat (2) cycle(s);
    s.rst_n = 0; cycle(s);
    cycle(idle());

    // long stall run to exercise counter saturation
    s = idle(); s.exld = 1; s.exwe = 1; s.exrd = 7; s.rs1 = 7; repeat (20) cycle(s);
    s = idle(); s.brt = 1; repeat (18) cycle(s);

    // randomized cycles; small register range makes matches frequent
    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 59) != 0);
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.exrd = 5'($urandom_range(0, 3)); s.mard = 5'($urandom_range(0, 3));
      s.isbr = 1'($urandom); s.brt = 1'($urandom);
      s.exwe = 1'($urandom); s.mawe = 1'($urandom);
      s.exld = 1'($urandom); s.mald = 1'($urandom);
      s.req = 1'($urandom);
      s.rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(s);
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("queue_drain", 9'(exp_q.size()), 9'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
